// File: rtl/mem_master_pkg.sv
// Shared types and constants for the mem_master request controller.
// The optional burst feature is selected with MEM_MASTER_BURST_EN.
package mem_master_pkg;

    localparam int ADDRSIZE_DEF = 16;
    localparam int WORDSIZE_DEF = 4;
    localparam int LENSIZE_DEF  = 4;

    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/mem_master_if.sv
// Client-side channels of mem_master: request, write data, write completion
// and read response. The client uses the master modport, mem_master the slave one.
interface mem_master_if
    import mem_master_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int LENSIZE  = LENSIZE_DEF
);
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDRSIZE-1:0] req_addr;
    logic [LENSIZE-1:0]  req_len;

    logic                wdata_valid;
    logic                wdata_ready;
    logic [WORDSIZE-1:0] wdata;
    logic                wr_done;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [WORDSIZE-1:0] rsp_data;
    logic                rsp_last;

    modport master (
        output req_valid, req_we, req_addr, req_len,
        output wdata_valid, wdata,
        output rsp_ready,
        input  req_ready, wdata_ready, wr_done,
        input  rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len,
        input  wdata_valid, wdata,
        input  rsp_ready,
        output req_ready, wdata_ready, wr_done,
        output rsp_valid, rsp_data, rsp_last
    );

endinterface

// File: rtl/mem_beat_ctr.sv
// Burst address/beat counter shared by the write and read paths.
// With MEM_MASTER_BURST_EN undefined every burst is one beat and no beat counter exists.
module mem_beat_ctr #(
    parameter int ADDRSIZE = 16,
    parameter int LENSIZE  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [ADDRSIZE-1:0] load_addr,
    input  logic [LENSIZE-1:0]  load_len,
    output logic [ADDRSIZE-1:0] addr,
    output logic                last
);

    logic [ADDRSIZE-1:0] addr_reg, addr_next;

    // Natural overflow of the adder gives the modulo-2^ADDRSIZE wrap.
    always_comb begin
        addr_next = addr_reg;
        if (load) begin
            addr_next = load_addr;
        end else if (step) begin
            addr_next = addr_reg + ADDRSIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg <= '0;
        end else begin
            addr_reg <= addr_next;
        end
    end

    assign addr = addr_reg;

`ifdef MEM_MASTER_BURST_EN
    logic [LENSIZE-1:0] beats_left_reg, beats_left_next;

    always_comb begin
        beats_left_next = beats_left_reg;
        if (load) begin
            beats_left_next = load_len;
        end else if (step) begin
            beats_left_next = beats_left_reg - LENSIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_left_reg <= '0;
        end else begin
            beats_left_reg <= beats_left_next;
        end
    end

    assign last = (beats_left_reg == '0);
`else
    logic unused_len;
    assign unused_len = ^load_len;
    assign last       = 1'b1;
`endif

endmodule

// File: rtl/mem_master.sv
// Request-side controller for memory_unit: turns single/burst word requests into
// wren/rden cycles and returns read data on a valid/ready channel (bursts: MEM_MASTER_BURST_EN).
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int LENSIZE  = LENSIZE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    mem_master_if.slave         bus,
    output logic                mem_wren,
    output logic                mem_rden,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WORDSIZE-1:0] mem_d,
    input  logic [WORDSIZE-1:0] mem_q
);

    state_t              state_reg, state_next;
    logic                inflight_reg, inflight_next;
    logic                pend_last_reg, pend_last_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [WORDSIZE-1:0] rsp_data_reg, rsp_data_next;
    logic                rsp_last_reg, rsp_last_next;
    logic                wr_done_reg, wr_done_next;

    logic                accept;
    logic                wr_beat;
    logic                rd_issue;
    logic                rsp_take;
    logic [ADDRSIZE-1:0] cur_addr;
    logic                last_beat;

    mem_beat_ctr #(
        .ADDRSIZE (ADDRSIZE),
        .LENSIZE  (LENSIZE)
    ) u_beat_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (wr_beat | rd_issue),
        .load_addr (bus.req_addr),
        .load_len  (bus.req_len),
        .addr      (cur_addr),
        .last      (last_beat)
    );

    // A read is only issued once the previous beat has left the response
    // register (or is leaving it this cycle), so one output register suffices.
    always_comb begin
        accept   = (state_reg == ST_IDLE) && bus.req_valid;
        wr_beat  = (state_reg == ST_WRITE) && bus.wdata_valid;
        rd_issue = (state_reg == ST_READ) && !inflight_reg &&
                   (!rsp_valid_reg || bus.rsp_ready);
        rsp_take = rsp_valid_reg && bus.rsp_ready;
    end

    always_comb begin
        state_next     = state_reg;
        inflight_next  = rd_issue;
        pend_last_next = rd_issue ? last_beat : pend_last_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_last_next  = rsp_last_reg;
        wr_done_next   = wr_beat && last_beat;

        if (rsp_take) begin
            rsp_valid_next = 1'b0;
        end
        if (inflight_reg) begin
            rsp_valid_next = 1'b1;
            rsp_data_next  = mem_q;
            rsp_last_next  = pend_last_reg;
        end

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (bus.req_we == MEM_OP_WRITE) ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_beat && last_beat) begin
                    state_next = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rd_issue && last_beat) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rsp_take && rsp_last_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            inflight_reg  <= 1'b0;
            pend_last_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_last_reg  <= 1'b0;
            wr_done_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            inflight_reg  <= inflight_next;
            pend_last_reg <= pend_last_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_last_reg  <= rsp_last_next;
            wr_done_reg   <= wr_done_next;
        end
    end

    assign bus.req_ready   = (state_reg == ST_IDLE);
    assign bus.wdata_ready = (state_reg == ST_WRITE) && !rst;
    assign bus.wr_done     = wr_done_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_data    = rsp_data_reg;
    assign bus.rsp_last    = rsp_last_reg;

    // Memory strobes are held off while rst is high, whatever the state.
    assign mem_wren = wr_beat && !rst;
    assign mem_rden = rd_issue && !rst;
    assign mem_addr = (!rst && (state_reg == ST_WRITE || state_reg == ST_READ)) ? cur_addr : '0;
    assign mem_d    = (!rst && state_reg == ST_WRITE) ? bus.wdata : '0;

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master with a memory_unit model and a reference word store.
// Burst expectations follow MEM_MASTER_BURST_EN: without it every request is one beat.
module tb_mem_master;
    import mem_master_pkg::*;

    localparam int AW = 16;
    localparam int WW = 4;
    localparam int LW = 4;
`ifdef MEM_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_wren, mem_rden;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_d;
    logic [WW-1:0] mem_q = '0;

    mem_master_if #(.ADDRSIZE(AW), .WORDSIZE(WW), .LENSIZE(LW)) bus ();

    mem_master #(.ADDRSIZE(AW), .WORDSIZE(WW), .LENSIZE(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_wren (mem_wren),
        .mem_rden (mem_rden),
        .mem_addr (mem_addr),
        .mem_d    (mem_d),
        .mem_q    (mem_q)
    );

    always #5 clk = ~clk;

    // memory_unit model: writes at the edge, read data valid for the following cycle
    logic [WW-1:0] tb_mem  [0:65535] = '{default: '0};
    logic [WW-1:0] ref_mem [0:65535] = '{default: '0};

    always @(posedge clk) begin
        if (mem_wren) tb_mem[mem_addr] <= mem_d;
        if (mem_rden) mem_q <= tb_mem[mem_addr];
    end

    int checks = 0;
    int passes = 0;

    task automatic do_write(input logic [AW-1:0] addr, input int len, input bit gaps,
                            input logic [WW-1:0] base, input bit desc);
        int            nb;
        int            i;
        int            budget;
        logic          valid;
        logic [WW-1:0] dv;
        logic [AW-1:0] ea;
        nb = BURST ? len + 1 : 1;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = MEM_OP_WRITE; bus.req_addr = addr; bus.req_len = LW'(len);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL wr_req_ready got %b exp 1", bus.req_ready); else passes++;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_addr = AW'($urandom); bus.req_len = LW'($urandom);
        i = 0; budget = 0;
        while (i < nb && budget < 200) begin
            valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            dv    = desc ? WW'(int'(base) - i) : WW'($urandom);
            ea    = addr + AW'(i);
            bus.wdata_valid = valid; bus.wdata = dv;
            @(negedge clk);
            checks++; if (bus.wdata_ready !== 1'b1) $display("FAIL wdata_ready got %b exp 1", bus.wdata_ready); else passes++;
            checks++; if (mem_wren !== valid) $display("FAIL mem_wren got %b exp %b", mem_wren, valid); else passes++;
            checks++; if (mem_rden !== 1'b0) $display("FAIL wr_mem_rden got %b exp 0", mem_rden); else passes++;
            checks++; if (bus.wr_done !== 1'b0) $display("FAIL wr_done_early got %b exp 0", bus.wr_done); else passes++;
            if (valid) begin
                checks++; if (mem_addr !== ea) $display("FAIL wr_addr got %h exp %h", mem_addr, ea); else passes++;
                checks++; if (mem_d !== dv) $display("FAIL wr_data got %h exp %h", mem_d, dv); else passes++;
                ref_mem[ea] = dv;
                i++;
            end
            @(posedge clk); #1;
            budget++;
        end
        bus.wdata_valid = 1'b0;
        checks++; if (i != nb) $display("FAIL wr_timeout beats %0d exp %0d", i, nb); else passes++;
        @(negedge clk);
        checks++; if (bus.wr_done !== 1'b1) $display("FAIL wr_done got %b exp 1", bus.wr_done); else passes++;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL wr_idle got %b exp 1", bus.req_ready); else passes++;
        checks++; if (bus.wdata_ready !== 1'b0) $display("FAIL wr_end_ready got %b exp 0", bus.wdata_ready); else passes++;
        checks++; if (mem_wren !== 1'b0) $display("FAIL wr_end_wren got %b exp 0", mem_wren); else passes++;
        $display("WR addr=%h len=%0d beats=%0d", addr, len, nb);
    endtask

    // mode 0: rsp_ready always high, 1: random, 2: hold off beat 1 for 3 cycles
    task automatic do_read(input logic [AW-1:0] addr, input int len, input int mode);
        int            nb;
        int            issued;
        int            recv;
        int            t;
        int            stall_cnt;
        int            issue_t [16];
        logic          rdy;
        logic          exp_v;
        logic          acc_now;
        logic          exp_rden;
        logic [AW-1:0] ea;
        nb = BURST ? len + 1 : 1;
        issued = 0; recv = 0; t = 0; stall_cnt = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = MEM_OP_READ; bus.req_addr = addr; bus.req_len = LW'(len);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL rd_req_ready got %b exp 1", bus.req_ready); else passes++;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_addr = AW'($urandom); bus.req_len = LW'($urandom);
        while (recv < nb && t < 200) begin
            t++;
            exp_v = (recv < issued) && (t >= issue_t[recv] + 2);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 2) != 0);
                default: begin
                    rdy = 1'b1;
                    if (recv == 1 && exp_v && stall_cnt < 3) begin
                        rdy = 1'b0;
                        stall_cnt++;
                    end
                end
            endcase
            bus.rsp_ready = rdy;
            @(negedge clk);
            checks++; if (bus.rsp_valid !== exp_v) $display("FAIL rsp_valid t=%0d got %b exp %b", t, bus.rsp_valid, exp_v); else passes++;
            if (exp_v) begin
                ea = addr + AW'(recv);
                checks++; if (bus.rsp_data !== ref_mem[ea]) $display("FAIL rsp_data beat %0d got %h exp %h", recv, bus.rsp_data, ref_mem[ea]); else passes++;
                checks++; if (bus.rsp_last !== (recv == nb - 1)) $display("FAIL rsp_last beat %0d got %b exp %b", recv, bus.rsp_last, recv == nb - 1); else passes++;
            end
            acc_now  = exp_v && rdy;
            exp_rden = (issued < nb) && (issued == recv + int'(acc_now));
            checks++; if (mem_rden !== exp_rden) $display("FAIL mem_rden t=%0d got %b exp %b", t, mem_rden, exp_rden); else passes++;
            checks++; if (mem_wren !== 1'b0) $display("FAIL rd_mem_wren got %b exp 0", mem_wren); else passes++;
            checks++; if (bus.req_ready !== 1'b0) $display("FAIL rd_busy got %b exp 0", bus.req_ready); else passes++;
            if (exp_rden) begin
                ea = addr + AW'(issued);
                checks++; if (mem_addr !== ea) $display("FAIL rd_addr got %h exp %h", mem_addr, ea); else passes++;
                issue_t[issued] = t;
                issued++;
            end
            if (acc_now) recv++;
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b0;
        checks++; if (recv != nb) $display("FAIL rd_timeout beats %0d exp %0d", recv, nb); else passes++;
        if (mode == 0) begin
            checks++; if (t != 2 * nb + 1) $display("FAIL rd_duration got %0d exp %0d", t, 2 * nb + 1); else passes++;
        end
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL rd_idle got %b exp 1", bus.req_ready); else passes++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rd_end_valid got %b exp 0", bus.rsp_valid); else passes++;
        $display("RD addr=%h len=%0d beats=%0d mode=%0d cycles=%0d", addr, len, nb, mode, t);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (mem_wren !== 1'b0) $display("FAIL rst_wren got %b exp 0", mem_wren); else passes++;
            checks++; if (mem_rden !== 1'b0) $display("FAIL rst_rden got %b exp 0", mem_rden); else passes++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_req_ready got %b exp 1", bus.req_ready); else passes++;
        checks++; if (bus.wdata_ready !== 1'b0) $display("FAIL rst_wdata_ready got %b exp 0", bus.wdata_ready); else passes++;
        checks++; if (bus.wr_done !== 1'b0) $display("FAIL rst_wr_done got %b exp 0", bus.wr_done); else passes++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid); else passes++;
        checks++; if (bus.rsp_last !== 1'b0) $display("FAIL rst_rsp_last got %b exp 0", bus.rsp_last); else passes++;
        checks++; if (bus.rsp_data !== '0) $display("FAIL rst_rsp_data got %h exp 0", bus.rsp_data); else passes++;
        checks++; if (mem_addr !== '0) $display("FAIL rst_mem_addr got %h exp 0", mem_addr); else passes++;
        checks++; if (mem_d !== '0) $display("FAIL rst_mem_d got %h exp 0", mem_d); else passes++;
        $display("RESET released");
    endtask

    task automatic test_single();
        do_write(16'h0005, 0, 1'b0, 4'hA, 1'b1);
        do_read(16'h0005, 0, 0);
    endtask

    task automatic test_burst();
        do_write(16'h0000, 15, 1'b0, 4'hF, 1'b1);
        do_read(16'h0000, 15, 0);
    endtask

    task automatic test_stall();
        do_read(16'h0000, 3, 2);
    endtask

    task automatic test_wrap();
        do_write(16'hFFFE, 2, 1'b1, 4'h0, 1'b0);
        do_read(16'hFFFE, 2, 1);
    endtask

    task automatic test_len7();
        do_write(16'h0028, 7, 1'b0, 4'h9, 1'b1);
        do_read(16'h0028, 7, 0);
    endtask

    task automatic test_rst_midread();
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = MEM_OP_READ; bus.req_addr = 16'h0005; bus.req_len = '0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL mid_req_ready got %b exp 1", bus.req_ready); else passes++;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (mem_rden !== 1'b1) $display("FAIL mid_rden got %b exp 1", mem_rden); else passes++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_rden !== 1'b0) $display("FAIL mid_rst_rden got %b exp 0", mem_rden); else passes++;
        checks++; if (mem_wren !== 1'b0) $display("FAIL mid_rst_wren got %b exp 0", mem_wren); else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid got %b exp 0", bus.rsp_valid); else passes++;
            checks++; if (bus.req_ready !== 1'b1) $display("FAIL mid_req_ready_after got %b exp 1", bus.req_ready); else passes++;
            checks++; if (mem_rden !== 1'b0) $display("FAIL mid_rden_after got %b exp 0", mem_rden); else passes++;
        end
        bus.rsp_ready = 1'b0;
        $display("RST during read: response discarded");
        do_read(16'h0005, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addr;
        int            len;
        for (int n = 0; n < 12; n++) begin
            addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 31))
                                                : AW'(32'h0000FFF0 + $urandom_range(0, 15));
            len  = $urandom_range(0, 15);
            if ($urandom_range(0, 1) != 0) do_write(addr, len, 1'b1, 4'h0, 1'b0);
            else                           do_read(addr, len, 1);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_len = '0;
        bus.wdata_valid = 1'b0; bus.wdata = '0; bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_wrap();
        test_rst_midread();
        test_len7();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
